// File: rtl/dmem_pkg.sv
// dmem_pkg: MMIO offsets, default unmapped read value and decode regions for dmem_responder
package dmem_pkg;
  localparam logic [3:0] MMIO_CYC_LO   = 4'd0;
  localparam logic [3:0] MMIO_CYC_HI   = 4'd1;
  localparam logic [3:0] MMIO_WR_CNT   = 4'd2;
  localparam logic [3:0] MMIO_RD_CNT   = 4'd3;
  localparam logic [3:0] MMIO_WP_LIMIT = 4'd4;
  localparam logic [15:0] DMEM_OOB_DATA = 16'hDEAD;
`ifdef DMEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {REGION_RAM, REGION_MMIO, REGION_OOB} region_e;
endpackage

// File: rtl/dmem_mmio_regs.sv
// dmem_mmio_regs: cycle counter with high-half snapshot, access counters, WP_LIMIT and MMIO read mux
// WP_LIMIT is writable only when DMEM_WRITE_PROTECT_EN is defined; otherwise it stays 0.
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [3:0]  off_i,
  input  logic [15:0] wdata_i,
  input  logic        ram_wr_i,
  input  logic        ram_rd_i,
  output logic [15:0] rdata_o,
  output logic [15:0] wp_limit_o
);
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] snap_q, snap_d, wr_q, wr_d, rd_q, rd_d, wpl_q, wpl_d;
  logic        wr_sel, cyc_clr;
  assign wr_sel  = sel_i & we_i;
  assign cyc_clr = wr_sel & (off_i == MMIO_CYC_LO || off_i == MMIO_CYC_HI);
  always_comb begin
    cyc_d  = cyc_clr ? '0 : cyc_q + 32'd1;
    snap_d = cyc_clr ? '0 : (sel_i && !we_i && off_i == MMIO_CYC_LO) ? cyc_q[31:16] : snap_q;
    wr_d   = (wr_sel && off_i == MMIO_WR_CNT) ? '0 : (ram_wr_i && wr_q != '1) ? wr_q + 16'd1 : wr_q;
    rd_d   = (wr_sel && off_i == MMIO_RD_CNT) ? '0 : (ram_rd_i && rd_q != '1) ? rd_q + 16'd1 : rd_q;
    wpl_d  = (WP_EN && wr_sel && off_i == MMIO_WP_LIMIT) ? wdata_i : wpl_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cyc_q  <= '0;
      snap_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      wpl_q  <= '0;
    end else begin
      cyc_q  <= cyc_d;
      snap_q <= snap_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      wpl_q  <= wpl_d;
    end
  assign wp_limit_o = wpl_q;
  assign rdata_o = off_i == MMIO_CYC_LO   ? cyc_q[15:0] :
                   off_i == MMIO_CYC_HI   ? snap_q :
                   off_i == MMIO_WR_CNT   ? wr_q :
                   off_i == MMIO_RD_CNT   ? rd_q :
                   off_i == MMIO_WP_LIMIT ? wpl_q : '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: DEPTH-word RAM plus MMIO counter window with registered read data and sticky error flags
// Optional write protection below WP_LIMIT is enabled by defining DMEM_WRITE_PROTECT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [15:0] MMIO_BASE = 16'hFF00,
  parameter logic [15:0] OOB_DATA  = DMEM_OOB_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        we,
  output logic [15:0] data_out,
  output logic        oob_err,
  output logic        wp_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [15:0] ram_q [DEPTH];
  logic [15:0] moff, mmio_rdata, wp_limit, data_out_q, data_out_d;
  logic [AW-1:0] idx;
  logic        ram_wr, ram_rd, wp_hit, oob_q, wp_q;
  region_e     region;
  assign moff   = addr - MMIO_BASE;
  assign idx    = addr[AW-1:0];
  assign region = 32'(addr) < DEPTH ? REGION_RAM : moff < 16'd16 ? REGION_MMIO : REGION_OOB;
  assign wp_hit = region == REGION_RAM && we && addr < wp_limit;
  assign ram_wr = region == REGION_RAM && we && !wp_hit;
  assign ram_rd = region == REGION_RAM && !we;
  always_ff @(posedge clk)
    if (ram_wr) ram_q[idx] <= data_in;
  // Write cycles leave the last read result in place.
  assign data_out_d = we ? data_out_q :
                      region == REGION_RAM  ? ram_q[idx] :
                      region == REGION_MMIO ? mmio_rdata : OOB_DATA;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_out_q <= '0;
      oob_q      <= 1'b0;
      wp_q       <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      oob_q      <= oob_q | (region == REGION_OOB);
      wp_q       <= wp_q | wp_hit;
    end
  dmem_mmio_regs u_mmio (
    .clk        (clk),
    .rst        (rst),
    .sel_i      (region == REGION_MMIO),
    .we_i       (we),
    .off_i      (moff[3:0]),
    .wdata_i    (data_in),
    .ram_wr_i   (ram_wr),
    .ram_rd_i   (ram_rd),
    .rdata_o    (mmio_rdata),
    .wp_limit_o (wp_limit)
  );
  assign data_out = data_out_q;
  assign oob_err  = oob_q;
  assign wp_err   = WP_EN & wp_q;
endmodule
